// File: rtl/muldiv_unit_pkg.sv
// rtl/muldiv_unit_pkg.sv - multiply/divide op codes and op classification helpers
package muldiv_unit_pkg;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    function automatic logic op_is_signed(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

    function automatic logic op_is_muldiv(input logic [2:0] op);
        return op <= MD_DIVU;
    endfunction

    function automatic logic op_is_div(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_unit_negate_cond.sv
// rtl/muldiv_unit_negate_cond.sv - conditional two's-complement negation
module negate_cond #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] din,
    input  logic             sel,
    output logic [WIDTH-1:0] dout
);

    assign dout = sel ? (~din + WIDTH'(1)) : din;

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative shift-add multiply / restoring divide with HI/LO registers
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam int         CW     = $clog2(WIDTH) + 1;

    logic [1:0]         state;
    logic [CW-1:0]      cnt;
    logic               is_div, neg_res, neg_rem, div_zero;
    // Multiply: acc = product, opa = shifted multiplicand, opb = multiplier.
    // Divide: acc[WIDTH:0] = partial remainder, opa[WIDTH-1:0] = dividend/quotient, opb = divisor.
    logic [2*WIDTH-1:0] acc, opa;
    logic [WIDTH-1:0]   opb;

    logic               signed_op;
    logic [WIDTH-1:0]   abs_a, abs_b, quo_fix, rem_fix;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH:0]     rem_sh, rem_diff;
    logic               q_bit;

    assign signed_op = op_is_signed(op);
    assign busy      = (state != S_IDLE);

    negate_cond #(.WIDTH(WIDTH)) u_abs_a (.din(a), .sel(signed_op & a[WIDTH-1]), .dout(abs_a));
    negate_cond #(.WIDTH(WIDTH)) u_abs_b (.din(b), .sel(signed_op & b[WIDTH-1]), .dout(abs_b));

    negate_cond #(.WIDTH(2*WIDTH)) u_fix_prod (.din(acc), .sel(neg_res), .dout(prod_fix));
    negate_cond #(.WIDTH(WIDTH)) u_fix_quo (.din(opa[WIDTH-1:0]), .sel(neg_res), .dout(quo_fix));
    negate_cond #(.WIDTH(WIDTH)) u_fix_rem (.din(acc[WIDTH-1:0]), .sel(neg_rem), .dout(rem_fix));

    assign rem_sh   = {acc[WIDTH-1:0], opa[WIDTH-1]};
    assign rem_diff = rem_sh - {1'b0, opb};
    assign q_bit    = (rem_sh >= {1'b0, opb});

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            is_div   <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            acc      <= '0;
            opa      <= '0;
            opb      <= '0;
            done     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (op_is_muldiv(op)) begin
                            is_div   <= op_is_div(op);
                            neg_res  <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
                            neg_rem  <= signed_op & a[WIDTH-1];
                            div_zero <= (b == '0);
                            acc      <= '0;
                            opa      <= {{WIDTH{1'b0}}, abs_a};
                            opb      <= abs_b;
                            cnt      <= '0;
                            state    <= S_RUN;
                        end else if (op == MD_MTHI) begin
                            hi <= a;
                        end else if (op == MD_MTLO) begin
                            lo <= a;
                        end
                    end
                end
                S_RUN: begin
                    if (is_div) begin
                        acc[WIDTH:0]   <= q_bit ? rem_diff : rem_sh;
                        opa[WIDTH-1:0] <= {opa[WIDTH-2:0], q_bit};
                    end else begin
                        if (opb[0]) begin
                            acc <= acc + opa;
                        end
                        opa <= opa << 1;
                        opb <= opb >> 1;
                    end
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    // A zero divisor still yields remainder = a naturally; only the quotient is forced.
                    if (is_div) begin
                        lo <= div_zero ? '1 : quo_fix;
                        hi <= rem_fix;
                    end else begin
                        {hi, lo} <= prod_fix;
                    end
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - scoreboard testbench for muldiv_unit
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset, start;
    logic [2:0]   op;
    logic [W-1:0] a, b;
    logic         busy, done;
    logic [W-1:0] hi, lo;

    int           n_vec = 0;
    int           n_err = 0;
    logic [2*W-1:0] sb[$];
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk  (clk),
        .reset(reset),
        .start(start),
        .op   (op),
        .a    (a),
        .b    (b),
        .busy (busy),
        .done (done),
        .hi   (hi),
        .lo   (lo)
    );

    function automatic logic [2*W-1:0] ref_model(input logic [2:0] o, input logic [W-1:0] x,
                                                 input logic [W-1:0] y);
        int sx, sy;
        longint unsigned ux;
        sx = x;
        sy = y;
        ux = 64'(x);
        case (o)
            MD_MULT:  return 64'(longint'(sx) * longint'(sy));
            MD_MULTU: return ux * 64'(y);
            MD_DIV: begin
                if (y == 0) return {x, {W{1'b1}}};
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, x};
                return {32'(sx % sy), 32'(sx / sy)};
            end
            default: begin
                if (y == 0) return {x, {W{1'b1}}};
                return {x % y, x / y};
            end
        endcase
    endfunction

    task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && done) begin
            if (sb.size() == 0) begin
                check("spurious_done", 64'(done), 64'(0));
            end else begin
                logic [2*W-1:0] e;
                e = sb.pop_front();
                check("result", {hi, lo}, e);
                m_hi = e[2*W-1:W];
                m_lo = e[W-1:0];
            end
        end
    end

    task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        int t = 0;
        while ((busy || (o > MD_DIVU && done)) && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) check("issue_timeout", 64'(busy), 64'(0));
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        if (o <= MD_DIVU) sb.push_back(ref_model(o, x, y));
        @(negedge clk);
        start = 1'b0;
        if (o > MD_DIVU) begin
            if (o == MD_MTHI) m_hi = x;
            else if (o == MD_MTLO) m_lo = x;
            check("move_hi", 64'(hi), 64'(m_hi));
            check("move_lo", 64'(lo), 64'(m_lo));
            check("move_no_done", 64'(done), 64'(0));
        end
    endtask

    task automatic wait_done();
        int t = 0;
        while (!done && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) check("done_timeout", 64'(done), 64'(1));
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((busy || done) && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) check("idle_timeout", 64'(busy), 64'(0));
    endtask

    initial begin
        int bc;
        logic [W-1:0] x, y;
        logic [2:0]   o;
        reset = 1'b1;
        start = 1'b0;
        op    = '0;
        a     = '0;
        b     = '0;
        repeat (2) @(negedge clk);
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_done", 64'(done), 64'(0));
        check("reset_hilo", {hi, lo}, 64'(0));
        reset = 1'b0;
        @(negedge clk);

        issue(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        bc = 0;
        while (busy && bc < 100) begin
            bc++;
            @(negedge clk);
        end
        check("busy_cycles", 64'(bc), 64'(W + 1));
        check("done_after_busy", 64'(done), 64'(1));
        check("multu_max", {hi, lo}, 64'hFFFF_FFFE_0000_0001);

        issue(MD_MULT, 32'hFFFF_FFF9, 32'd3);
        issue(MD_DIV, 32'hFFFF_FFF9, 32'd2);
        issue(MD_DIVU, 32'd100, 32'd0);
        issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle();
        check("div_min_neg1", {hi, lo}, 64'h0000_0000_8000_0000);

        issue(MD_MTHI, 32'h1234, 32'd0);

        issue(MD_MULTU, $urandom, $urandom);
        repeat (3) @(negedge clk);
        start = 1'b1;
        op    = MD_MTLO;
        a     = 32'h1234;
        @(negedge clk);
        start = 1'b0;
        check("mtlo_in_run_ignored", 64'(lo), 64'(m_lo));
        check("mtlo_in_run_busy", 64'(busy), 64'(1));
        wait_done();
        wait_idle();

        issue(MD_MULTU, 32'd12345, 32'd678);
        wait_done();
        issue(MD_DIVU, 32'd17, 32'd5);
        check("b2b_zero_idle", 64'(busy), 64'(1));
        repeat (4) @(negedge clk);
        a = 32'd999;
        b = 32'd1;
        wait_done();
        check("b2b_divu", {hi, lo}, {32'd2, 32'd3});
        wait_idle();

        issue(MD_MULTU, $urandom, $urandom);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_hilo", {hi, lo}, 64'(0));
        sb.delete();
        m_hi = '0;
        m_lo = '0;
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        issue(MD_MULTU, 32'd6, 32'd7);
        wait_done();
        check("after_abort_6x7", {hi, lo}, 64'd42);

        for (int i = 0; i < 40; i++) begin
            o = 3'($urandom_range(0, 7));
            x = $urandom;
            y = $urandom;
            case ($urandom_range(0, 7))
                0: y = '0;
                1: begin x = 32'h8000_0000; y = '1; end
                2: y = 32'($urandom_range(1, 9));
                3: x = 32'($urandom_range(0, 99));
                default: ;
            endcase
            issue(o, x, y);
        end
        wait_idle();
        check("scoreboard_drained", 64'(sb.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
